// File: rtl/deadlock_trace_unit_if.sv
// Report-record handshake between the deadlock trace unit and its consumer.
// The master drives records; the slave returns ready.
interface deadlock_trace_unit_if #(
    parameter int unsigned IDX_W = 2
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [1:0]       rpt_kind;
    logic             rpt_first;
    logic [IDX_W-1:0] rpt_idx;
    logic [7:0]       rpt_cycle_id;
    logic [7:0]       rpt_comp_id;

    modport master (
        output rpt_valid,
        output rpt_kind,
        output rpt_first,
        output rpt_idx,
        output rpt_cycle_id,
        output rpt_comp_id,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_kind,
        input  rpt_first,
        input  rpt_idx,
        input  rpt_cycle_id,
        input  rpt_comp_id,
        output rpt_ready
    );
endinterface

// File: rtl/deadlock_trace_unit.sv
// Qualifies a deadlock from the detector network, then walks each dependence cycle
// by following the token and emits START/PROC/ABORT/END report records.
module deadlock_trace_unit #(
    parameter int unsigned PROC_NUM      = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_LEN       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                token_hold,
    deadlock_trace_unit_if.master rpt
);

    localparam int unsigned IDX_W    = ($clog2(PROC_NUM) > 1) ? $clog2(PROC_NUM) : 1;
    localparam logic [7:0]  STABLE_W = 8'(STABLE_CYCLES);
    localparam logic [7:0]  MAX_W    = 8'(MAX_LEN);

    localparam logic [1:0] KindStart = 2'd0;
    localparam logic [1:0] KindProc  = 2'd1;
    localparam logic [1:0] KindAbort = 2'd2;
    localparam logic [1:0] KindEnd   = 2'd3;

    typedef enum logic [2:0] {StIdle, StQualify, StDetected, StReport, StDone} state_e;

    state_e              state_q;
    logic [PROC_NUM-1:0] det_q;
    logic [PROC_NUM-1:0] done_q;
    logic [PROC_NUM-1:0] origin_q;
    logic [PROC_NUM-1:0] vec_q;
    logic                stall_q;
    logic                clear_q;
    logic [7:0]          cnt_q;
    logic [7:0]          len_q;
    logic [7:0]          cyc_q;

    logic [PROC_NUM-1:0] eff_vec;
    logic [PROC_NUM-1:0] pending;
    logic [PROC_NUM-1:0] low_onehot;
    logic [IDX_W-1:0]    low_idx;
    logic [IDX_W-1:0]    high_idx;
    logic [IDX_W-1:0]    org_idx;
    logic [7:0]          cyc_inc;
    logic [7:0]          cnt_inc;
    logic                at_origin;
    logic                accept;

    logic                valid_c;
    logic [1:0]          kind_c;
    logic                first_c;
    logic [IDX_W-1:0]    idx_c;
    logic [7:0]          cycle_c;
    logic [7:0]          comp_c;
    logic [PROC_NUM-1:0] origin_c;

    // While a record is stalled the captured vector stands in for the live input,
    // so the record and the decisions derived from it cannot change under the consumer.
    assign eff_vec   = stall_q ? vec_q : dl_in_vec;
    assign pending   = det_q & ~done_q;
    assign at_origin = |(eff_vec & origin_q);
    assign cyc_inc   = (cyc_q == 8'hFF) ? 8'hFF : cyc_q + 8'd1;
    assign cnt_inc   = cnt_q + 8'd1;

    always_comb begin
        low_idx    = '0;
        low_onehot = '0;
        org_idx    = '0;
        for (int i = int'(PROC_NUM) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx       = IDX_W'(i);
                low_onehot    = '0;
                low_onehot[i] = 1'b1;
            end
            if (origin_q[i]) begin
                org_idx = IDX_W'(i);
            end
        end
        high_idx = '0;
        for (int i = 0; i < int'(PROC_NUM); i++) begin
            if (eff_vec[i]) begin
                high_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        valid_c  = 1'b0;
        kind_c   = KindStart;
        first_c  = 1'b0;
        idx_c    = '0;
        cycle_c  = 8'd0;
        comp_c   = 8'd0;
        origin_c = '0;
        unique case (state_q)
            StDetected: begin
                valid_c = 1'b1;
                if (|pending) begin
                    kind_c   = KindStart;
                    first_c  = (done_q == '0);
                    idx_c    = low_idx;
                    cycle_c  = cyc_inc;
                    comp_c   = 8'd1;
                    origin_c = low_onehot;
                end else begin
                    kind_c  = KindEnd;
                    cycle_c = cyc_q;
                end
            end
            StReport: begin
                // A returned token closes the cycle silently; abort outranks a PROC.
                if (!at_origin) begin
                    if (len_q == MAX_W) begin
                        valid_c = 1'b1;
                        kind_c  = KindAbort;
                        idx_c   = org_idx;
                        cycle_c = cyc_q;
                    end else if (|eff_vec) begin
                        valid_c = 1'b1;
                        kind_c  = KindProc;
                        idx_c   = high_idx;
                        cycle_c = cyc_q;
                        comp_c  = len_q + 8'd1;
                    end
                end
            end
            StDone: begin
                kind_c  = KindEnd;
                cycle_c = cyc_q;
            end
            default: ;
        endcase
    end

    assign accept     = valid_c && rpt.rpt_ready;
    assign token_hold = valid_c && !rpt.rpt_ready;

    assign rpt.rpt_valid    = valid_c;
    assign rpt.rpt_kind     = kind_c;
    assign rpt.rpt_first    = first_c;
    assign rpt.rpt_idx      = idx_c;
    assign rpt.rpt_cycle_id = cycle_c;
    assign rpt.rpt_comp_id  = comp_c;
    assign origin           = origin_c;
    assign token_clear      = clear_q;
    assign dl_detect_out    = (state_q == StDetected) || (state_q == StReport) ||
                              (state_q == StDone);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            det_q    <= '0;
            done_q   <= '0;
            origin_q <= '0;
            vec_q    <= '0;
            stall_q  <= 1'b0;
            clear_q  <= 1'b0;
            cnt_q    <= 8'd0;
            len_q    <= 8'd0;
            cyc_q    <= 8'd0;
        end else begin
            clear_q <= 1'b0;
            stall_q <= token_hold;
            if (token_hold) begin
                vec_q <= eff_vec;
            end
            unique case (state_q)
                StIdle: begin
                    if (|dl_in_vec) begin
                        det_q   <= dl_in_vec;
                        cnt_q   <= 8'd1;
                        state_q <= (STABLE_CYCLES == 1) ? StDetected : StQualify;
                    end
                end
                StQualify: begin
                    if (dl_in_vec == '0) begin
                        det_q   <= '0;
                        cnt_q   <= 8'd0;
                        state_q <= StIdle;
                    end else begin
                        det_q <= det_q | dl_in_vec;
                        cnt_q <= cnt_inc;
                        if (cnt_inc == STABLE_W) begin
                            state_q <= StDetected;
                        end
                    end
                end
                StDetected: begin
                    if (accept) begin
                        if (|pending) begin
                            origin_q <= low_onehot;
                            cyc_q    <= cyc_inc;
                            len_q    <= 8'd1;
                            state_q  <= StReport;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StReport: begin
                    if (at_origin) begin
                        done_q  <= done_q | origin_q;
                        clear_q <= 1'b1;
                        state_q <= StDetected;
                    end else if (len_q == MAX_W) begin
                        if (accept) begin
                            done_q  <= done_q | origin_q;
                            clear_q <= 1'b1;
                            state_q <= StDetected;
                        end
                    end else if (accept) begin
                        done_q <= done_q | (eff_vec & det_q);
                        len_q  <= len_q + 8'd1;
                    end
                end
                StDone: ;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_deadlock_trace_unit.sv
// Directed bench for deadlock_trace_unit: qualification, cycle walk with stall,
// return-to-origin, END, reset during a walk and MAX_LEN abort.
module tb_deadlock_trace_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dl_in_vec;
    logic       dl_detect_out;
    logic [3:0] origin;
    logic       token_clear;
    logic       token_hold;

    int errors = 0;
    int checks = 0;
    int proc_accepts = 0;

    always #5 clock = ~clock;

    deadlock_trace_unit_if #(.IDX_W(2)) rpt_if ();

    deadlock_trace_unit #(
        .PROC_NUM     (4),
        .STABLE_CYCLES(4),
        .MAX_LEN      (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dl_in_vec    (dl_in_vec),
        .dl_detect_out(dl_detect_out),
        .origin       (origin),
        .token_clear  (token_clear),
        .token_hold   (token_hold),
        .rpt          (rpt_if)
    );

    always @(posedge clock) begin
        if (!reset && rpt_if.rpt_valid && rpt_if.rpt_ready && rpt_if.rpt_kind == 2'd1) begin
            proc_accepts++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rec(input string tag, input int kind, input int idx, input int cyc,
                             input int comp);
        check({tag, ".valid"}, 32'(rpt_if.rpt_valid), 1);
        check({tag, ".kind"}, 32'(rpt_if.rpt_kind), kind);
        check({tag, ".idx"}, 32'(rpt_if.rpt_idx), idx);
        check({tag, ".cycle"}, 32'(rpt_if.rpt_cycle_id), cyc);
        check({tag, ".comp"}, 32'(rpt_if.rpt_comp_id), comp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Four sampling edges of non-zero tokens qualify a deadlock.
    task automatic qualify(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                           input logic [3:0] v3);
        logic [3:0] seq [4];
        seq = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            dl_in_vec = seq[i];
            @(negedge clock);
            check("qual.detect", 32'(dl_detect_out), 0);
            check("qual.valid", 32'(rpt_if.rpt_valid), 0);
            step();
        end
        dl_in_vec = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dl_in_vec = 4'b0000;
        rpt_if.rpt_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst.detect", 32'(dl_detect_out), 0);
        check("rst.valid", 32'(rpt_if.rpt_valid), 0);
        check("rst.origin", 32'(origin), 0);
        check("rst.clear", 32'(token_clear), 0);
        check("rst.hold", 32'(token_hold), 0);
        reset = 1'b0;
        step();

        // Glitch of 3 cycles is rejected.
        dl_in_vec = 4'b0001;
        repeat (3) begin
            @(negedge clock);
            check("glitch.detect", 32'(dl_detect_out), 0);
            check("glitch.valid", 32'(rpt_if.rpt_valid), 0);
            step();
        end
        dl_in_vec = 4'b0000;
        @(negedge clock);
        check("glitch.drop", 32'(dl_detect_out), 0);
        step();

        // Fresh qualification accumulates det = 0111.
        qualify(4'b0001, 4'b0010, 4'b0100, 4'b0001);
        @(negedge clock);
        check("det.detect", 32'(dl_detect_out), 1);
        check_rec("start1", 0, 0, 1, 1);
        check("start1.first", 32'(rpt_if.rpt_first), 1);
        check("start1.origin", 32'(origin), 32'h1);
        step();

        // PROC with 5 cycles of back-pressure.
        dl_in_vec = 4'b0010;
        rpt_if.rpt_ready = 1'b0;
        @(negedge clock);
        check("rep.origin", 32'(origin), 0);
        for (int i = 0; i < 5; i++) begin
            check_rec("proc.stall", 1, 1, 1, 2);
            check("proc.hold", 32'(token_hold), 1);
            step();
            @(negedge clock);
        end
        rpt_if.rpt_ready = 1'b1;
        #1;
        check_rec("proc.go", 1, 1, 1, 2);
        check("proc.nohold", 32'(token_hold), 0);
        step();
        check("proc.count", 32'(proc_accepts), 1);

        // Token back at origin: no record, clear pulse, START for proc 2.
        dl_in_vec = 4'b0001;
        @(negedge clock);
        check("ret.valid", 32'(rpt_if.rpt_valid), 0);
        check("ret.clear0", 32'(token_clear), 0);
        step();
        dl_in_vec = 4'b0000;
        @(negedge clock);
        check("ret.clear", 32'(token_clear), 1);
        check_rec("start2", 0, 2, 2, 1);
        check("start2.first", 32'(rpt_if.rpt_first), 0);
        check("start2.origin", 32'(origin), 32'h4);
        step();
        dl_in_vec = 4'b0100;
        @(negedge clock);
        check("ret2.clear", 32'(token_clear), 0);
        check("ret2.valid", 32'(rpt_if.rpt_valid), 0);
        step();
        dl_in_vec = 4'b0000;
        @(negedge clock);
        check_rec("end", 3, 0, 2, 0);
        step();
        @(negedge clock);
        check("done.valid", 32'(rpt_if.rpt_valid), 0);
        check("done.detect", 32'(dl_detect_out), 1);
        step();
        @(negedge clock);
        check("done.stay", 32'(dl_detect_out), 1);

        // Reset mid-walk.
        reset = 1'b1;
        step();
        reset = 1'b0;
        qualify(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        step();
        dl_in_vec = 4'b0010;
        @(negedge clock);
        check_rec("pre_rst", 1, 1, 1, 2);
        reset = 1'b1;
        #1;
        check("mid_rst.valid", 32'(rpt_if.rpt_valid), 0);
        check("mid_rst.detect", 32'(dl_detect_out), 0);
        step();
        check("mid_rst.hold", 32'(token_hold), 0);
        reset = 1'b0;

        // Requalify with det = 0111, then run into the MAX_LEN abort.
        qualify(4'b0010, 4'b0001, 4'b0100, 4'b0100);
        @(negedge clock);
        check_rec("ab.start", 0, 0, 1, 1);
        step();
        dl_in_vec = 4'b0010;
        @(negedge clock);
        check_rec("ab.proc2", 1, 1, 1, 2);
        step();
        dl_in_vec = 4'b0100;
        @(negedge clock);
        check_rec("ab.proc3", 1, 2, 1, 3);
        step();
        dl_in_vec = 4'b0010;
        @(negedge clock);
        check_rec("ab.abort", 2, 0, 1, 0);
        step();
        dl_in_vec = 4'b0000;
        @(negedge clock);
        check("ab.clear", 32'(token_clear), 1);
        check("ab.detect", 32'(dl_detect_out), 1);
        check_rec("ab.end", 3, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
